req_pending_latch: RTL and testbench

//   Sticky request capture stage that directly feeds the 32-to-5 priority encoder.

---
 rtl/req_pending_latch.sv | 79 +++++++
 tb/tb_req_pending_latch.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/req_pending_latch.sv
// Sticky request capture ahead of a 32-to-5 priority encoder: latches request
// pulses, applies a programmable mask and retires one request per cycle by index.
module req_pending_latch #(
  parameter int          N    = 32,
  parameter int          IDXW = 5,
  parameter logic [31:0] MRST = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            mask_we,
  input  logic [N-1:0]    mask_in,
  input  logic            clr_valid,
  input  logic [IDXW-1:0] clr_idx,
  input  logic            ovr_clr,
  output logic [N-1:0]    x_out,
  output logic            en_out,
  output logic [5:0]      pend_cnt,
  output logic [N-1:0]    overrun,
  output logic            clr_miss
);

  logic [N-1:0] pending;
  logic [N-1:0] mask;
  logic [N-1:0] pending_nxt;
  logic [N-1:0] overrun_nxt;
  logic [N-1:0] clr_hit;
  logic         clr_miss_nxt;

  // Count is one bit wider than IDXW so a full vector reads 32, not 0.
  function automatic logic [5:0] popcount(input logic [N-1:0] v);
    logic [5:0] sum;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + 6'(v[i]);
    end
    return sum;
  endfunction

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    clr_hit     = '0;
    pending_nxt = pending;
    overrun_nxt = overrun;
    if (clr_valid) begin
      clr_hit[clr_idx] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      // A set always beats a same-edge clear, so a request is never dropped.
      pending_nxt[i] = req[i] | (pending[i] & ~clr_hit[i]);
      // A fresh overrun beats the bulk clear for that bit.
      overrun_nxt[i] = (req[i] & pending[i]) | (overrun[i] & ~ovr_clr);
    end
    clr_miss_nxt = clr_valid & ~pending[clr_idx];
  end

  // NOTE: state registers use non-blocking assignments so all bits update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      mask     <= MRST;
      overrun  <= '0;
      clr_miss <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      overrun  <= overrun_nxt;
      clr_miss <= clr_miss_nxt;
      if (mask_we) begin
        mask <= mask_in;
      end
    end
  end

  // Masked sources stay latched; unmasking exposes them without a new request.
  assign x_out    = pending & mask;
  assign en_out   = |x_out;
  assign pend_cnt = popcount(x_out);

endmodule

// File: tb/tb_req_pending_latch.sv
// Directed self-checking bench for req_pending_latch with hand-computed expectations.
module tb_req_pending_latch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req;
  logic        mask_we;
  logic [31:0] mask_in;
  logic        clr_valid;
  logic [4:0]  clr_idx;
  logic        ovr_clr;
  logic [31:0] x_out;
  logic        en_out;
  logic [5:0]  pend_cnt;
  logic [31:0] overrun;
  logic        clr_miss;

  int total = 0;
  int bad   = 0;

  req_pending_latch dut (
    .clk(clk), .rst(rst), .req(req), .mask_we(mask_we), .mask_in(mask_in),
    .clr_valid(clr_valid), .clr_idx(clr_idx), .ovr_clr(ovr_clr),
    .x_out(x_out), .en_out(en_out), .pend_cnt(pend_cnt),
    .overrun(overrun), .clr_miss(clr_miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Apply the currently driven inputs at one edge, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0; req = '0; mask_we = 1'b0; mask_in = '0;
    clr_valid = 1'b0; clr_idx = '0; ovr_clr = 1'b0;
  endtask

  task automatic clear_bit(input int idx);
    clr_valid = 1'b1;
    clr_idx   = 5'(idx);
    tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; mask_we = 1'b0; mask_in = '0;
    clr_valid = 1'b0; clr_idx = '0; ovr_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // 1. reset state, mask reset to all ones
    check("rst_x", x_out, 32'h0);
    check("rst_en", 32'(en_out), 32'h0);
    check("rst_cnt", 32'(pend_cnt), 32'h0);
    check("rst_ovr", overrun, 32'h0);
    check("rst_miss", 32'(clr_miss), 32'h0);
    req = 32'h1; tick();
    check("rst_mask_x", x_out, 32'h1);
    clear_bit(0);
    check("clr0_x", x_out, 32'h0);
    check("clr0_nomiss", 32'(clr_miss), 32'h0);

    // 2. two sources, retire bit 31
    req = 32'h8000_0001; tick();
    check("two_x", x_out, 32'h8000_0001);
    check("two_en", 32'(en_out), 32'h1);
    check("two_cnt", 32'(pend_cnt), 32'd2);
    clear_bit(31);
    check("ret31_x", x_out, 32'h0000_0001);
    check("ret31_cnt", 32'(pend_cnt), 32'd1);
    clear_bit(0);
    check("ret0_en", 32'(en_out), 32'h0);

    // 3. set beats clear, overrun capture and clear
    req = 32'h20; tick();
    req = 32'h20; clr_valid = 1'b1; clr_idx = 5'd5; tick();
    check("setwin_x", x_out, 32'h20);
    check("setwin_ovr", overrun, 32'h20);
    ovr_clr = 1'b1; tick();
    check("ovrclr", overrun, 32'h0);
    check("ovrclr_x", x_out, 32'h20);
    req = 32'h20; ovr_clr = 1'b1; tick();
    check("ovr_beats_clr", overrun, 32'h20);
    ovr_clr = 1'b1; tick();
    check("ovrclr2", overrun, 32'h0);
    clear_bit(5);
    check("clr5_x", x_out, 32'h0);

    // 4. mask write, masked latching, full-count boundary
    mask_we = 1'b1; mask_in = 32'h0000_00FF; tick();
    req = 32'hFFFF_FFFF; tick();
    check("mask_x", x_out, 32'h0000_00FF);
    check("mask_cnt", 32'(pend_cnt), 32'd8);
    mask_we = 1'b1; mask_in = 32'h0; tick();
    check("mask0_en", 32'(en_out), 32'h0);
    mask_we = 1'b1; mask_in = 32'hFFFF_FFFF; tick();
    check("unmask_x", x_out, 32'hFFFF_FFFF);
    check("full_cnt", 32'(pend_cnt), 32'd32);
    mask_we = 1'b1; mask_in = 32'h0000_00FF; tick();
    clear_bit(20);
    mask_we = 1'b1; mask_in = 32'hFFFF_FFFF; tick();
    check("masked_clr_x", x_out, 32'hFFEF_FFFF);
    check("masked_clr_cnt", 32'(pend_cnt), 32'd31);
    for (int i = 0; i < 32; i++) begin
      if (i != 20) clear_bit(i);
    end
    check("drain_x", x_out, 32'h0);
    check("drain_miss", 32'(clr_miss), 32'h0);

    // 5. clear of a non-pending bit
    clear_bit(7);
    check("miss_pulse", 32'(clr_miss), 32'h1);
    check("miss_x", x_out, 32'h0);
    tick();
    check("miss_gone", 32'(clr_miss), 32'h0);

    // 6. reset overrides a same-edge request and clear
    mask_we = 1'b1; mask_in = 32'h0000_F0F0; tick();
    req = 32'h0000_F000; tick();
    check("pre_rst_x", x_out, 32'h0000_F000);
    req = 32'h0000_1000; tick();
    check("pre_rst_ovr", overrun, 32'h0000_1000);
    clr_valid = 1'b1; clr_idx = 5'd3; tick();
    check("pre_rst_miss", 32'(clr_miss), 32'h1);
    rst = 1'b1; req = 32'h1; clr_valid = 1'b1; clr_idx = 5'd2; tick();
    check("mid_rst_x", x_out, 32'h0);
    check("mid_rst_ovr", overrun, 32'h0);
    check("mid_rst_miss", 32'(clr_miss), 32'h0);
    check("mid_rst_cnt", 32'(pend_cnt), 32'h0);
    req = 32'h1; tick();
    check("mid_rst_mask", x_out, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
